miriscv_instr_mem_responder: RTL and testbench

Memory-side responder for the core's instruction fetch interface (req/addr in, rvalid/rdata out). It accepts one fetch request at a time and checks the address for alignment and range. It reads a single-port synchronous instruction SRAM with a configurable number of wait states and returns exactly one response per accepted request. It sits between the fetch stage and the instruction SRAM macro, replacing the ideal memory model in SoC builds.

---
 rtl/miriscv_instr_mem_responder.sv | 143 ++++++++++++++
 tb/tb_miriscv_instr_mem_responder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/miriscv_instr_mem_responder.sv
// -----------------------------------------------------------------------------
// miriscv_instr_mem_responder
//
// Purpose: memory-side responder for the core's instruction fetch port. It
// accepts one fetch at a time, checks the byte address for alignment and range,
// reads a single-port synchronous instruction SRAM (with WAIT_STATES extra
// cycles before the read data is captured) and returns exactly one response per
// accepted request unless the request is flushed or reset.
//
// Handshake: instr_req_i is a level. It is sampled only while the FSM is IDLE
// and flush_i is low; that cycle is the accept cycle. The response is a single
// cycle strobe on instr_rvalid_o; instr_rdata_o and instr_err_o are meaningful
// only while instr_rvalid_o=1 and are forced to 0 otherwise. There is no
// backpressure on the response and never more than one request outstanding.
//
// Ports:
//   clk_i           in   clock, rising edge
//   arst_i          in   asynchronous reset, active high
//   instr_req_i     in   fetch request (level)
//   instr_addr_i    in   fetch byte address
//   instr_rvalid_o  out  one-cycle response strobe
//   instr_rdata_o   out  response data, 0 unless instr_rvalid_o
//   instr_err_o     out  access fault, 0 unless instr_rvalid_o
//   flush_i         in   abort the outstanding request, no response returned
//   mem_en_o        out  SRAM read enable, single-cycle pulse on accept
//   mem_addr_o      out  SRAM word index
//   mem_rdata_i     in   SRAM read data, valid the cycle after mem_en_o
//   busy_o          out  FSM is not IDLE
// -----------------------------------------------------------------------------
module miriscv_instr_mem_responder #(
    parameter int unsigned     XLEN            = 32,
    parameter int unsigned     MEM_DEPTH_WORDS = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR       = '0,
    parameter int unsigned     WAIT_STATES     = 0
) (
    input  logic                               clk_i,
    input  logic                               arst_i,
    input  logic                               instr_req_i,
    input  logic [XLEN-1:0]                    instr_addr_i,
    output logic                               instr_rvalid_o,
    output logic [XLEN-1:0]                    instr_rdata_o,
    output logic                               instr_err_o,
    input  logic                               flush_i,
    output logic                               mem_en_o,
    output logic [$clog2(MEM_DEPTH_WORDS)-1:0] mem_addr_o,
    input  logic [31:0]                        mem_rdata_i,
    output logic                               busy_o
);

    localparam int unsigned     AW        = $clog2(MEM_DEPTH_WORDS);
    localparam logic [XLEN-1:0] MEM_BYTES = XLEN'(MEM_DEPTH_WORDS * 4);
    localparam logic [3:0]      WS        = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [XLEN-1:0] offset;
    logic            addr_fault;
    logic            mem_en_c;
    logic            resp_fire;

    // Unsigned wrap-around makes addresses below BASE_ADDR land far above the
    // window, so a single compare covers both ends of the range.
    assign offset     = instr_addr_i - BASE_ADDR;
    assign addr_fault = (instr_addr_i[1:0] != 2'b00) || (offset >= MEM_BYTES);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        mem_en_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (instr_req_i && !flush_i) begin
                    if (addr_fault) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        mem_en_c = 1'b1;
                        cnt_d    = WS;
                        state_d  = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Flush wins over a capture in the same cycle.
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rdata_d = XLEN'(mem_rdata_i);
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The response strobe is combinational so a flush in the RESP cycle can
    // still suppress it.
    assign resp_fire      = (state_q == ST_RESP) && !flush_i;
    assign instr_rvalid_o = resp_fire;
    assign instr_rdata_o  = resp_fire ? rdata_q : '0;
    assign instr_err_o    = resp_fire & err_q;

    // The enable is decoded from live inputs in IDLE, so it is gated by reset
    // to keep every output low while arst_i is asserted.
    assign mem_en_o   = mem_en_c && !arst_i;
    assign mem_addr_o = mem_en_o ? offset[2 +: AW] : '0;
    assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_miriscv_instr_mem_responder.sv
module tb_miriscv_instr_mem_responder;

    localparam int          XLEN  = 32;
    localparam int          DEPTH = 1024;
    localparam int          AW    = 10;
    localparam int          WS    = 2;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    // ---------------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    logic arst_i = 1'b1;
    always #5 clk = ~clk;

    logic            instr_req_i = 1'b0;
    logic [31:0]     instr_addr_i = '0;
    logic            flush_i = 1'b0;
    logic            instr_rvalid_o;
    logic [31:0]     instr_rdata_o;
    logic            instr_err_o;
    logic            mem_en_o;
    logic [AW-1:0]   mem_addr_o;
    logic [31:0]     mem_rdata_i = '0;
    logic            busy_o;

    miriscv_instr_mem_responder #(
        .XLEN            (XLEN),
        .MEM_DEPTH_WORDS (DEPTH),
        .BASE_ADDR       (BASE),
        .WAIT_STATES     (WS)
    ) dut (
        .clk_i          (clk),
        .arst_i         (arst_i),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .instr_err_o    (instr_err_o),
        .flush_i        (flush_i),
        .mem_en_o       (mem_en_o),
        .mem_addr_o     (mem_addr_o),
        .mem_rdata_i    (mem_rdata_i),
        .busy_o         (busy_o)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous SRAM: data appears the cycle after the enable and is held.
    logic [31:0] sram [DEPTH];
    always @(posedge clk) if (mem_en_o) mem_rdata_i <= sram[mem_addr_o];

    // ---------------------------------------------------------------- scoreboard
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          mon_en  = 1'b0;
    bit          busy_exp = 1'b0;
    logic [31:0] exp_q[$];
    logic        exp_err_q[$];
    int          exp_due_q[$];
    int          en_cyc_q[$];
    logic [31:0] en_addr_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, required %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the expected queues.
    always @(negedge clk) begin
        if (mon_en && !arst_i) begin
            check("busy", 32'(busy_o), 32'(busy_exp));
            if (mem_en_o) begin
                if (en_cyc_q.size() == 0) begin
                    check("mem_en_unexpected", 32'(mem_en_o), 32'h0);
                end else begin
                    check("mem_en_cycle", 32'(cyc), 32'(en_cyc_q.pop_front()));
                    check("mem_addr", 32'(mem_addr_o), en_addr_q.pop_front());
                end
            end else if (en_cyc_q.size() != 0 && cyc >= en_cyc_q[0]) begin
                check("mem_en_missing", 32'(mem_en_o), 32'h1);
                void'(en_cyc_q.pop_front());
                void'(en_addr_q.pop_front());
            end
            if (instr_rvalid_o) begin
                if (exp_due_q.size() == 0) begin
                    check("rvalid_unexpected", 32'(instr_rvalid_o), 32'h0);
                end else begin
                    check("rvalid_cycle", 32'(cyc), 32'(exp_due_q.pop_front()));
                    check("rdata", instr_rdata_o, exp_q.pop_front());
                    check("err", 32'(instr_err_o), 32'(exp_err_q.pop_front()));
                end
            end else begin
                check("rdata_idle_zero", instr_rdata_o, 32'h0);
                check("err_idle_zero", 32'(instr_err_o), 32'h0);
                if (exp_due_q.size() != 0 && cyc >= exp_due_q[0]) begin
                    check("rvalid_missing", 32'(instr_rvalid_o), 32'h1);
                    void'(exp_due_q.pop_front());
                    void'(exp_q.pop_front());
                    void'(exp_err_q.pop_front());
                end
            end
        end
    end

    // ---------------------------------------------------------------- driver tasks
    // Reference: window offset is the byte distance from BASE modulo 2^32; a
    // fetch faults unless it is word aligned and inside DEPTH words.
    task automatic do_req(input logic [31:0] a, input bit hold, input int flush_in);
        longint unsigned off;
        bit              flt;
        int              lat, flush_k, acc, c_end, widx;
        off     = (64'(a) + 64'h1_0000_0000 - 64'(BASE)) % 64'h1_0000_0000;
        flt     = (a % 4 != 0) || (off >= 64'(DEPTH * 4));
        widx    = flt ? 0 : int'(off / 4);
        lat     = flt ? 1 : 2 + WS;
        flush_k = (flush_in > lat) ? lat : flush_in;
        @(posedge clk); #1;
        acc          = cyc;
        instr_req_i  = 1'b1;
        instr_addr_i = a;
        flush_i      = 1'b0;
        busy_exp     = 1'b0;
        if (!flt) begin
            en_cyc_q.push_back(acc);
            en_addr_q.push_back(32'(widx));
        end
        if (flush_k == 0) begin
            exp_q.push_back(flt ? 32'h0 : sram[widx]);
            exp_err_q.push_back(flt);
            exp_due_q.push_back(acc + lat);
        end
        c_end = (flush_k != 0) ? flush_k : lat;
        for (int c = 1; c <= c_end; c++) begin
            @(posedge clk); #1;
            if (!hold) instr_req_i = 1'b0;
            flush_i  = (c == flush_k);
            busy_exp = 1'b1;
        end
        @(posedge clk); #1;
        instr_req_i = 1'b0;
        flush_i     = 1'b0;
        busy_exp    = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            instr_req_i = 1'b0;
            flush_i     = 1'b0;
            busy_exp    = 1'b0;
        end
    endtask

    // A request presented together with flush in IDLE must not be accepted.
    task automatic flush_in_idle();
        @(posedge clk); #1;
        instr_req_i  = 1'b1;
        instr_addr_i = BASE + 32'h8;
        flush_i      = 1'b1;
        busy_exp     = 1'b0;
        @(posedge clk); #1;
        instr_req_i = 1'b0;
        flush_i     = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rvalid"}, 32'(instr_rvalid_o), 32'h0);
        check({tag, "_rdata"}, instr_rdata_o, 32'h0);
        check({tag, "_err"}, 32'(instr_err_o), 32'h0);
        check({tag, "_mem_en"}, 32'(mem_en_o), 32'h0);
        check({tag, "_mem_addr"}, 32'(mem_addr_o), 32'h0);
        check({tag, "_busy"}, 32'(busy_o), 32'h0);
    endtask

    // Reset pulsed asynchronously in the middle of WAIT drops the request.
    task automatic reset_mid_wait();
        @(posedge clk); #1;
        instr_req_i  = 1'b1;
        instr_addr_i = BASE + 32'h40;
        busy_exp     = 1'b0;
        en_cyc_q.push_back(cyc);
        en_addr_q.push_back(32'd16);
        @(posedge clk); #1;
        instr_req_i = 1'b0;
        busy_exp    = 1'b1;
        #2;
        arst_i      = 1'b1;
        instr_req_i = 1'b1;
        busy_exp    = 1'b0;
        #1;
        check_all_zero("reset_mid_wait");
        @(posedge clk); #1;
        arst_i      = 1'b0;
        instr_req_i = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 6))
            0, 1, 2: a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            3:       a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
            4:       a = BASE + 32'(DEPTH * 4) + 32'(4 * $urandom_range(0, 3));
            5:       a = BASE - 32'(4 * $urandom_range(1, 4));
            default: a = $urandom();
        endcase
        return a;
    endfunction

    // ---------------------------------------------------------------- main
    initial begin
        for (int i = 0; i < DEPTH; i++) sram[i] = $urandom();
        sram[5] = 32'h00A00093;

        instr_req_i  = 1'b1;
        instr_addr_i = BASE;
        #2;
        check_all_zero("reset");
        instr_req_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        arst_i = 1'b0;
        mon_en = 1'b1;
        idle_cycles(2);

        do_req(BASE + 32'h14, 1'b0, 0);       // word 5, known data
        do_req(BASE, 1'b1, 0);                // req held high until rvalid
        do_req(BASE + 32'h6, 1'b0, 0);        // misaligned
        do_req(BASE + 32'h1000, 1'b0, 0);     // just past the window
        do_req(32'h7FFF_FFFC, 1'b0, 0);       // just below base, wraps
        do_req(BASE + 32'hFFC, 1'b0, 0);      // last word, index 1023
        do_req(BASE + 32'h20, 1'b1, 2);       // flushed in WAIT
        do_req(BASE + 32'h24, 1'b0, 0);       // serviced right after
        do_req(BASE + 32'h28, 1'b0, 2 + WS);  // flushed in RESP
        do_req(BASE + 32'h3, 1'b1, 1);        // fault flushed in RESP
        flush_in_idle();
        idle_cycles(1);
        reset_mid_wait();
        idle_cycles(3);
        do_req(BASE + 32'h40, 1'b0, 0);       // normal service after reset

        for (int t = 0; t < 300; t++) begin
            int fk;
            fk = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2 + WS) : 0;
            if ($urandom_range(0, 15) == 0) flush_in_idle();
            do_req(rand_addr(), 1'($urandom_range(0, 1)), fk);
            idle_cycles($urandom_range(0, 2));
        end

        idle_cycles(6);
        check("resp_queue_drained", 32'(exp_due_q.size()), 32'h0);
        check("mem_en_queue_drained", 32'(en_cyc_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout at cycle %0d: got no end of test, required finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
